// File: rtl/port_arbiter_if.sv
// Signal bundle between one output-port arbiter, the four input FIFOs and the output mux.
// Handshake: a word moves downstream in the cycle after a grant only if ready_out was high when that grant was issued.
interface port_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int SEL_W     = 2
);
    logic [NUM_PORTS-1:0] req;
    logic                 ready_out;
    logic [NUM_PORTS-1:0] grant;
    logic [SEL_W-1:0]     mux_select;
    logic                 valid_out;
    logic                 busy;
    logic [3:0]           burst_cnt;
    logic [1:0]           state_dbg;

    modport master (
        input  req, ready_out,
        output grant, mux_select, valid_out, busy, burst_cnt, state_dbg
    );

    modport slave (
        output req, ready_out,
        input  grant, mux_select, valid_out, busy, burst_cnt, state_dbg
    );
endinterface

// File: rtl/port_arbiter.sv
// Round-robin scheduler for one switch output port: picks an input FIFO, pops it in
// bounded bursts under downstream backpressure, and drives the output mux select.
module port_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int SEL_W     = 2,
    parameter int MAX_BURST = 4
) (
    input logic          clk,
    input logic          rst,
    port_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XMIT  = 2'd2
    } state_t;

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic                 valid_q, valid_d;
    logic                 busy_q;
    logic [SEL_W-1:0]     winner;

    // Descending scan so the last hit, i.e. the port closest after ptr, wins.
    always_comb begin
        winner = ptr_q;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            if (bus.req[ptr_q + SEL_W'(k)]) winner = ptr_q + SEL_W'(k);
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        grant_d = '0;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    sel_d   = winner;
                    cnt_d   = 4'd0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!bus.req[sel_q]) begin
                    ptr_d   = sel_q;
                    state_d = IDLE;
                end else if (bus.ready_out) begin
                    grant_d = NUM_PORTS'(1) << sel_q;
                    cnt_d   = cnt_q + 4'd1;
                    state_d = XMIT;
                end
            end
            XMIT: begin
                // req here is post-pop, so a drained one-entry FIFO ends the burst.
                valid_d = 1'b1;
                if (cnt_q < MAX_B && bus.req[sel_q]) begin
                    state_d = GRANT;
                end else begin
                    ptr_d   = sel_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= SEL_W'(NUM_PORTS - 1);
            sel_q   <= '0;
            cnt_q   <= 4'd0;
            grant_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.grant      = grant_q;
    assign bus.mux_select = sel_q;
    assign bus.valid_out  = valid_q;
    assign bus.busy       = busy_q;
    assign bus.burst_cnt  = cnt_q;
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_port_arbiter.sv
// Bench for port_arbiter: directed scenarios plus random traffic, each cycle compared
// against a transaction-level round-robin model of the output port.
module tb_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    port_arbiter_if #(.NUM_PORTS(4), .SEL_W(2)) bus_a ();
    port_arbiter_if #(.NUM_PORTS(4), .SEL_W(2)) bus_b ();

    port_arbiter #(.NUM_PORTS(4), .SEL_W(2), .MAX_BURST(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.master)
    );

    port_arbiter #(.NUM_PORTS(4), .SEL_W(2), .MAX_BURST(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.master)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Model of dut_a: owner < 0 means nobody holds the output.
    localparam int MAXA = 4;
    int         m_owner = -1;
    int         m_last  = 3;
    int         m_beats = 0;
    int         m_sel   = 0;
    bit         m_popped = 1'b0;
    logic [3:0] m_grant = 4'd0;
    bit         m_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [3:0] r, input bit rdy, input bit rs);
        bit found;
        m_grant = 4'd0;
        m_valid = 1'b0;
        if (rs) begin
            m_owner = -1; m_popped = 1'b0; m_beats = 0; m_last = 3; m_sel = 0;
        end else if (m_owner < 0) begin
            if (r != 4'd0) begin
                found = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    if (!found && r[(m_last + k) % 4]) begin
                        m_owner = (m_last + k) % 4;
                        found = 1'b1;
                    end
                end
                m_sel   = m_owner;
                m_beats = 0;
            end
        end else if (m_popped) begin
            m_valid  = 1'b1;
            m_popped = 1'b0;
            if (!(m_beats < MAXA && r[m_owner])) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end else if (!r[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end else if (rdy) begin
            m_grant  = 4'd1 << m_owner;
            m_beats++;
            m_popped = 1'b1;
        end
    endtask

    task automatic cycle(input logic [3:0] r, input bit rdy, input bit rs = 1'b0);
        bus_a.req       = r;
        bus_a.ready_out = rdy;
        rst             = rs;
        model_step(r, rdy, rs);
        @(posedge clk);
        #1;
        chk("grant", bus_a.grant, m_grant);
        chk("mux_select", bus_a.mux_select, m_sel);
        chk("valid_out", bus_a.valid_out, m_valid);
        chk("busy", bus_a.busy, (m_owner >= 0));
        chk("burst_cnt", bus_a.burst_cnt, m_beats);
        if (bus_a.grant != 4'd0)
            chk("grant_matches_sel", bus_a.grant, 4'd1 << bus_a.mux_select);
    endtask

    logic [1:0] exp_q[$];
    logic [1:0] win_q[$];
    logic [3:0] cnt_seen_q[$];

    initial begin
        bus_a.req = 4'd0; bus_a.ready_out = 1'b0;
        bus_b.req = 4'd0; bus_b.ready_out = 1'b1;

        // Reset state.
        cycle(4'd0, 1'b0, 1'b1);
        cycle(4'd0, 1'b0, 1'b1);
        chk("rst_state", bus_a.state_dbg, 0);
        chk("rst_b_grant", bus_b.grant, 0);
        chk("rst_b_busy", bus_b.busy, 0);

        // Single beat from port 2.
        cycle(4'b0100, 1'b1);
        chk("t1_sel", bus_a.mux_select, 2);
        chk("t1_no_grant_yet", bus_a.grant, 0);
        cycle(4'b0100, 1'b1);
        chk("t1_grant", bus_a.grant, 4'b0100);
        cycle(4'b0000, 1'b1);
        chk("t1_valid", bus_a.valid_out, 1);
        chk("t1_busy_dropped", bus_a.busy, 0);
        cycle(4'b0000, 1'b1);
        chk("t1_valid_once", bus_a.valid_out, 0);

        // Bursts of four between ports 0 and 1.
        exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
        for (int i = 0; i < 30; i++) begin
            cycle(4'b0011, 1'b1);
            if (bus_a.grant != 4'd0) begin
                win_q.push_back(bus_a.mux_select);
                cnt_seen_q.push_back(bus_a.burst_cnt);
            end
        end
        chk("burst_grant_count_ge9", (win_q.size() >= 9), 1);
        for (int i = 0; i < 9 && i < win_q.size(); i++) begin
            chk($sformatf("burst_winner_%0d", i), win_q[i], exp_q[i]);
            chk($sformatf("burst_cnt_%0d", i), cnt_seen_q[i], (i % 4) + 1);
        end
        for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1);

        // Backpressure stall on port 3.
        cycle(4'b1000, 1'b0);
        chk("stall_sel", bus_a.mux_select, 3);
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1000, 1'b0);
            chk("stall_grant_zero", bus_a.grant, 0);
            chk("stall_state_grant", bus_a.state_dbg, 1);
        end
        cycle(4'b1000, 1'b1);
        chk("stall_release_grant", bus_a.grant, 4'b1000);
        cycle(4'b0000, 1'b1);
        chk("stall_valid", bus_a.valid_out, 1);

        // Request withdrawn while waiting in GRANT.
        cycle(4'b0100, 1'b0);
        chk("wd_sel", bus_a.mux_select, 2);
        cycle(4'b0000, 1'b0);
        chk("wd_grant", bus_a.grant, 0);
        chk("wd_idle", bus_a.state_dbg, 0);
        cycle(4'b1001, 1'b1);
        chk("wd_next_winner", bus_a.mux_select, 3);
        cycle(4'b1001, 1'b1);
        chk("wd_next_grant", bus_a.grant, 4'b1000);
        cycle(4'b0000, 1'b1);

        // Reset asserted while in XMIT.
        cycle(4'b0100, 1'b1);
        cycle(4'b0100, 1'b1);
        chk("rx_in_xmit", bus_a.state_dbg, 2);
        cycle(4'b0100, 1'b1, 1'b1);
        chk("rx_grant", bus_a.grant, 0);
        chk("rx_valid", bus_a.valid_out, 0);
        chk("rx_busy", bus_a.busy, 0);
        chk("rx_sel", bus_a.mux_select, 0);
        chk("rx_cnt", bus_a.burst_cnt, 0);
        cycle(4'b1010, 1'b1);
        chk("rx_first_sel", bus_a.mux_select, 1);
        cycle(4'b1010, 1'b1);
        chk("rx_first_grant", bus_a.grant, 4'b0010);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);

        // Single-beat bursts rotate through all four ports.
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        win_q.delete();
        bus_b.req = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            cycle(4'b0000, 1'b1);
            if (bus_b.grant != 4'd0) begin
                win_q.push_back(bus_b.mux_select);
                chk("rr_onehot", bus_b.grant, 4'd1 << bus_b.mux_select);
            end
        end
        bus_b.req = 4'b0000;
        chk("rr_grant_count", win_q.size(), 5);
        for (int i = 0; i < 5 && i < win_q.size(); i++)
            chk($sformatf("rr_winner_%0d", i), win_q[i], exp_q[i]);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
